sti_dac_gen: RTL and testbench
==============================

STI_DAC_GEN -- requirements
Module: sti_dac_gen

Interface
REQ-001 SHALL have parameter IN_W, default 16, parallel input word width (multiple of 8, 8..32).
REQ-002 SHALL have parameter MAX_BYTES, default 4, maximum frame length in bytes (1..8, MAX_BYTES*8 >= IN_W).
REQ-003 SHALL have parameter ADDR_W, default 8, pixel memory address width (depth 2^ADDR_W).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  input  1  request to capture a word; accepted only when ready=1.
REQ-007 SHALL have port ready  output  1  high in IDLE only.
REQ-008 SHALL have port pi_data  input  IN_W  parallel data word.
REQ-009 SHALL have port pi_length  input  clog2(MAX_BYTES)  frame length minus one, in bytes.
REQ-010 SHALL have ports pi_fill, pi_msb, pi_low, pi_end  input  1 each  alignment, bit order, half select, last-word flag.
REQ-011 SHALL have ports so_data, so_valid  output  1 each  serial bit and qualifier.
REQ-012 SHALL have ports pixel_wr  output  1, pixel_addr  output  ADDR_W, pixel_dataout  output  8, pixel_finish  output  1.

Function
REQ-013 SHALL register pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end on the edge where load=1 and ready=1; inputs are don't-care afterwards.
REQ-014 SHALL form an L-bit frame, L=(pi_length+1)*8: L<IN_W -> pi_low=1 selects pi_data[IN_W-1:IN_W-L], else pi_data[L-1:0]; L=IN_W -> pi_data; L>IN_W -> pi_fill=1 places data in the upper IN_W bits with zeros below, else zeros above and data in the lower IN_W bits.
REQ-015 SHALL bit-reverse the whole L-bit frame when pi_msb=0; frame bit L-1 is always transmitted first.
REQ-016 SHALL use states IDLE, DAC, SER, FILL, DONE; IDLE->DAC on accepted load.
REQ-017 DAC SHALL emit L/8 bytes, first-transmitted byte first, each over two cycles: cycle 1 pixel_wr=1 with pixel_addr/pixel_dataout valid; cycle 2 pixel_wr=0 and pixel_addr increments.
REQ-018 pixel_addr SHALL wrap modulo 2^ADDR_W; pixel_dataout SHALL be 0 whenever pixel_wr=0.
REQ-019 SER SHALL drive so_valid=1 for exactly L consecutive cycles starting the cycle after the last DAC write, one frame bit per cycle MSB-first; so_data=0 when so_valid=0.
REQ-020 After SER, SHALL go to FILL if captured pi_end=1, else IDLE (ready=1 the next cycle).
REQ-021 FILL SHALL write 0x00 at every remaining address using the REQ-017 two-cycle pattern, last write at address 2^ADDR_W-1; if pixel_addr has already wrapped to 0 after DAC, no fill writes occur.
REQ-022 DONE SHALL hold pixel_finish=1, pixel_wr=0, ready=0 until reset.
REQ-023 load while ready=0 SHALL be ignored with no side effect.

Reset
REQ-024 On reset=1 at a clock edge, SHALL enter IDLE with so_data=0, so_valid=0, pixel_wr=0, pixel_addr=0, pixel_dataout=0, pixel_finish=0, ready=1, from any state including mid-frame.
REQ-025 reset SHALL take priority over load in the same cycle.

Configuration
REQ-026 With STI_PARITY_EN defined, SER SHALL append one even-parity bit over the L frame bits, so so_valid lasts L+1 cycles; without it, no parity bit and so_valid lasts exactly L cycles.

Verification
REQ-027 IN_W=16, pi_data=16'hA5C3, pi_length=0, pi_low=1, pi_msb=1 -> one write 0xA5 at addr 0; so_data 1,0,1,0,0,1,0,1 over 8 valid cycles; ready returns.
REQ-028 pi_data=16'h1234, pi_length=2, pi_fill=1, pi_msb=0 -> frame 24'h002C48; writes 0x00,0x2C,0x48 at addrs 0..2; 24 valid bits.
REQ-029 pi_length=3, pi_fill=0, pi_msb=1, pi_end=1, data 16'hBEEF -> writes 00,00,BE,EF at 0..3; then 252 zero writes at 4..255; pixel_finish=1 held.
REQ-030 Reset asserted mid-SER at bit 5 -> next cycle all outputs zero, ready=1; following load starts at addr 0.
REQ-031 load pulsed during DAC and SER -> ignored; with STI_PARITY_EN, frame 8'h07 -> 9 valid cycles, last so_data=1.

Source files
------------

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: captures a parallel word and turns it into an L-bit frame. The
// frame is first written byte by byte into a pixel memory, then shifted out
// serially MSB-first. An optional tail fill zeroes the rest of the memory.
//
// Optional feature: define STI_PARITY_EN to append an even-parity bit after the
// L serial frame bits.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   load / ready    capture request; it is accepted only while ready (IDLE) is high
//   pi_data         parallel data word (IN_W bits)
//   pi_length       frame length in bytes, minus one
//   pi_fill         L > IN_W: 1 = data in the upper bits, 0 = data in the lower bits
//   pi_msb          0 = bit-reverse the whole frame
//   pi_low          L < IN_W: 1 = take the upper L bits of pi_data, 0 = the lower L bits
//   pi_end          last word: zero-fill the remaining memory, then raise pixel_finish
//   so_data/valid   serial bit and its qualifier
//   pixel_*         pixel memory write port and finish flag
module sti_dac_gen #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned ADDR_W    = 8,
    localparam int unsigned LEN_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    output logic              ready,
    input  logic [IN_W-1:0]   pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [7:0]        pixel_dataout,
    output logic              pixel_finish
);

    localparam int unsigned MAX_L = MAX_BYTES * 8;
    localparam int unsigned CNT_W = $clog2(MAX_L + 2);
`ifdef STI_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    typedef enum logic [2:0] {IDLE, DAC, SER, FILL, DONE} state_t;

    state_t             state_q, state_d;
    logic [MAX_L-1:0]   frame_q, frame_d;      // frame, left-justified: first bit at MAX_L-1
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // byte index in DAC, bit index in SER
    logic [LEN_W-1:0]   len_q, len_d;
    logic               end_q, end_d;
    logic               ready_q, ready_d;
    logic               pixel_wr_q, pixel_wr_d;
    logic [ADDR_W-1:0]  pixel_addr_q, pixel_addr_d;
    logic [7:0]         pixel_dataout_q, pixel_dataout_d;
    logic               so_valid_q, so_valid_d;
    logic               so_data_q, so_data_d;
    logic               pixel_finish_q, pixel_finish_d;
`ifdef STI_PARITY_EN
    logic               par_q, par_d;
`endif

    logic [MAX_L-1:0]   frame_new;
    logic [7:0]         dac_byte;
    logic [CNT_W-1:0]   ser_last;

    // Build the left-justified frame from the raw inputs. Bits below the
    // frame stay zero, so a bit-reversed frame lands left-justified as is.
    function automatic logic [MAX_L-1:0] build_frame(
        input logic [IN_W-1:0]  d,
        input logic [LEN_W-1:0] len,
        input logic             fill,
        input logic             msb,
        input logic             low
    );
        int unsigned      len_bits;
        logic [MAX_L-1:0] ext;
        logic [MAX_L-1:0] raw;
        logic [MAX_L-1:0] rev;
        len_bits = (32'(len) + 32'd1) * 32'd8;
        ext      = MAX_L'(d);
        if (len_bits < IN_W) begin
            raw = low ? (ext >> (IN_W - len_bits))
                      : ((ext << (MAX_L - len_bits)) >> (MAX_L - len_bits));
        end else if (len_bits == IN_W) begin
            raw = ext;
        end else begin
            raw = fill ? (ext << (len_bits - IN_W)) : ext;
        end
        for (int i = 0; i < int'(MAX_L); i++) begin
            rev[i] = raw[int'(MAX_L) - 1 - i];
        end
        return msb ? (raw << (MAX_L - len_bits)) : rev;
    endfunction

    assign frame_new = build_frame(pi_data, pi_length, pi_fill, pi_msb, pi_low);
    assign dac_byte  = 8'(frame_q >> (MAX_L - 32'd8 - 32'd8 * 32'(cnt_q)));
    assign ser_last  = CNT_W'(32'(len_q) * 32'd8 + 32'd7 + PAR_BITS);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            frame_q         <= '0;
            cnt_q           <= '0;
            len_q           <= '0;
            end_q           <= 1'b0;
            ready_q         <= 1'b1;
            pixel_wr_q      <= 1'b0;
            pixel_addr_q    <= '0;
            pixel_dataout_q <= '0;
            so_valid_q      <= 1'b0;
            so_data_q       <= 1'b0;
            pixel_finish_q  <= 1'b0;
`ifdef STI_PARITY_EN
            par_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            frame_q         <= frame_d;
            cnt_q           <= cnt_d;
            len_q           <= len_d;
            end_q           <= end_d;
            ready_q         <= ready_d;
            pixel_wr_q      <= pixel_wr_d;
            pixel_addr_q    <= pixel_addr_d;
            pixel_dataout_q <= pixel_dataout_d;
            so_valid_q      <= so_valid_d;
            so_data_q       <= so_data_d;
            pixel_finish_q  <= pixel_finish_d;
`ifdef STI_PARITY_EN
            par_q           <= par_d;
`endif
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d         = state_q;
        frame_d         = frame_q;
        cnt_d           = cnt_q;
        len_d           = len_q;
        end_d           = end_q;
        pixel_wr_d      = 1'b0;
        pixel_addr_d    = pixel_addr_q;
        pixel_dataout_d = 8'h00;
        so_valid_d      = 1'b0;
        so_data_d       = 1'b0;
`ifdef STI_PARITY_EN
        par_d           = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d         = DAC;
                    frame_d         = frame_new;
                    len_d           = pi_length;
                    end_d           = pi_end;
                    cnt_d           = '0;
                    pixel_wr_d      = 1'b1;
                    pixel_dataout_d = frame_new[MAX_L-1 -: 8];
`ifdef STI_PARITY_EN
                    par_d           = ^frame_new;
`endif
                end
            end
            DAC: begin
                if (pixel_wr_q) begin
                    pixel_addr_d = pixel_addr_q + ADDR_W'(1);
                    if (cnt_q == CNT_W'(len_q)) begin
                        // second cycle of the last write doubles as the first serial bit
                        state_d    = SER;
                        cnt_d      = '0;
                        so_valid_d = 1'b1;
                        so_data_d  = frame_q[MAX_L-1];
                        frame_d    = frame_q << 1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    pixel_wr_d      = 1'b1;
                    pixel_dataout_d = dac_byte;
                end
            end
            SER: begin
                if (cnt_q == ser_last) begin
                    if (end_q) begin
                        state_d    = FILL;
                        // an address already wrapped to 0 means nothing is left to fill
                        pixel_wr_d = (pixel_addr_q != '0);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    so_valid_d = 1'b1;
                    so_data_d  = frame_q[MAX_L-1];
                    frame_d    = frame_q << 1;
`ifdef STI_PARITY_EN
                    if (cnt_q == CNT_W'(32'(len_q) * 32'd8 + 32'd7)) begin
                        so_data_d = par_q;
                    end
`endif
                end
            end
            FILL: begin
                if (pixel_wr_q) begin
                    pixel_addr_d = pixel_addr_q + ADDR_W'(1);
                    if (pixel_addr_q == '1) begin
                        state_d = DONE;
                    end
                end else if (pixel_addr_q == '0) begin
                    state_d = DONE;
                end else begin
                    pixel_wr_d = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d        = (state_d == IDLE);
        pixel_finish_d = (state_d == DONE);
    end

    assign ready         = ready_q;
    assign pixel_wr      = pixel_wr_q;
    assign pixel_addr    = pixel_addr_q;
    assign pixel_dataout = pixel_dataout_q;
    assign so_valid      = so_valid_q;
    assign so_data       = so_data_q;
    assign pixel_finish  = pixel_finish_q;

endmodule

// File: tb/tb_sti_dac_gen.sv
// Bench for sti_dac_gen (IN_W=16, MAX_BYTES=4, ADDR_W=8). A queue of expected
// per-cycle outputs is built from the frame rules and compared every cycle.
module tb_sti_dac_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        ready;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill, pi_msb, pi_low, pi_end;
    logic        so_data, so_valid;
    logic        pixel_wr;
    logic [7:0]  pixel_addr;
    logic [7:0]  pixel_dataout;
    logic        pixel_finish;

    sti_dac_gen dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .ready         (ready),
        .pi_data       (pi_data),
        .pi_length     (pi_length),
        .pi_fill       (pi_fill),
        .pi_msb        (pi_msb),
        .pi_low        (pi_low),
        .pi_end        (pi_end),
        .so_data       (so_data),
        .so_valid      (so_valid),
        .pixel_wr      (pixel_wr),
        .pixel_addr    (pixel_addr),
        .pixel_dataout (pixel_dataout),
        .pixel_finish  (pixel_finish)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // expected observation: {ready, wr, addr, dataout, so_valid, so_data, finish}
    logic [20:0] q[$];
    logic [7:0]  m_addr = 8'h00;
    bit          m_done = 1'b0;
    logic [15:0] wlog[$];
    bit          slog[$];

    function automatic logic [20:0] mk(bit r, bit w, logic [7:0] ad, logic [7:0] dt,
                                       bit v, bit s, bit f);
        return {r, w, ad, dt, v, s, f};
    endfunction

    // Frame value right-justified: bit L-1 is transmitted first.
    function automatic logic [63:0] mframe(input logic [15:0] d, input int len,
                                           input bit fill, input bit msb, input bit low);
        int L;
        logic [63:0] v, r;
        L = (len + 1) * 8;
        v = 64'(d);
        if (L < 16) v = low ? (v >> (16 - L)) : (v & ((64'd1 << L) - 64'd1));
        else if (L > 16 && fill) v = v << (L - 16);
        if (!msb) begin
            r = '0;
            for (int i = 0; i < L; i++) r[i] = v[L-1-i];
            v = r;
        end
        return v;
    endfunction

    task automatic push_frame(input logic [15:0] d, input int len, input bit fill,
                              input bit msb, input bit low, input bit last);
        logic [63:0] v;
        logic [7:0]  a;
        int L, n, t;
        bit par;
        L = (len + 1) * 8;
        n = len + 1;
        v = mframe(d, len, fill, msb, low);
        par = ^v;
        t = L;
`ifdef STI_PARITY_EN
        t = L + 1;
`endif
        a = m_addr;
        for (int k = 0; k < n; k++) begin
            q.push_back(mk(0, 1, a, 8'(v >> (L - 8 - 8 * k)), 0, 0, 0));
            a = a + 8'd1;
            if (k < n - 1) q.push_back(mk(0, 0, a, 8'h00, 0, 0, 0));
        end
        for (int j = 0; j < t; j++)
            q.push_back(mk(0, 0, a, 8'h00, 1, (j < L) ? v[L-1-j] : par, 0));
        if (!last) begin
            m_addr = a;
        end else begin
            if (a == 8'h00) q.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0));
            for (int x = int'(a); x < 256 && a != 8'h00; x++) begin
                q.push_back(mk(0, 1, 8'(x), 8'h00, 0, 0, 0));
                if (x == 255) q.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 1));
                else q.push_back(mk(0, 0, 8'(x + 1), 8'h00, 0, 0, 0));
            end
            m_done = 1'b1;
            m_addr = 8'h00;
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin : compare
        logic [20:0] e, a;
        if (check_en) begin
            if (q.size() > 0) e = q.pop_front();
            else if (m_done) e = mk(0, 0, 8'h00, 8'h00, 0, 0, 1);
            else e = mk(1, 0, m_addr, 8'h00, 0, 0, 0);
            a = {ready, pixel_wr, pixel_addr, pixel_dataout, so_valid, so_data, pixel_finish};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, a, e);
            end
            if (pixel_wr) wlog.push_back({pixel_addr, pixel_dataout});
            if (so_valid) slog.push_back(so_data);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sbits();
        logic [63:0] v = '0;
        foreach (slog[i]) v = (v << 1) | 64'(slog[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input bit need_idle);
        int k = 0;
        while ((q.size() != 0 || (need_idle && m_done)) && k < 3000) begin
            tick();
            k++;
        end
        if (k >= 3000) begin
            n_err++;
            $display("FAIL wait_timeout: queue %0d entries left", q.size());
        end
    endtask

    task automatic send(input logic [15:0] d, input int len, input bit fill,
                        input bit msb, input bit low, input bit last);
        wait_drain(1'b1);
        wlog.delete();
        slog.delete();
        pi_data = d; pi_length = 2'(len); pi_fill = fill;
        pi_msb = msb; pi_low = low; pi_end = last;
        load = 1'b1;
        @(posedge clk);
        push_frame(d, len, fill, msb, low, last);
        #1;
        load = 1'b0;
        pi_data = 16'($urandom);
        {pi_length, pi_fill, pi_msb, pi_low, pi_end} = 6'($urandom);
    endtask

    task automatic do_reset(input bit with_load);
        reset = 1'b1;
        load = with_load;
        @(posedge clk);
        q.delete();
        m_addr = 8'h00;
        m_done = 1'b0;
        #1;
        reset = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
        pi_fill = 0; pi_msb = 0; pi_low = 0; pi_end = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_en = 1'b1;
        reset = 1'b0;
        check("reset_state", 64'({ready, pixel_wr, pixel_addr, pixel_dataout,
                                  so_valid, so_data, pixel_finish}), 64'h100000);

        // model pins
        check("model_a5", mframe(16'hA5C3, 0, 0, 1, 1), 64'hA5);
        check("model_2c48", mframe(16'h1234, 2, 1, 0, 0), 64'h002C48);
        check("model_beef", mframe(16'hBEEF, 3, 0, 1, 0), 64'hBEEF);
        check("model_rev16", mframe(16'h00F1, 1, 0, 0, 0), 64'h8F00);
        check("model_07", mframe(16'h0007, 0, 0, 1, 0), 64'h07);

        // single byte, upper half
        send(16'hA5C3, 0, 0, 1, 1, 0);
        wait_drain(1'b1);
        check("a_nwr", 64'(wlog.size()), 64'd1);
        check("a_wr0", 64'(wlog[0]), 64'h00A5);
        check("a_nbits", 64'(slog.size()), 64'd8 + 64'(dut.PAR_BITS));
        check("a_ready", 64'(ready), 64'd1);

        // 24-bit, fill high, reversed
        do_reset(1'b0);
        send(16'h1234, 2, 1, 0, 0, 0);
        wait_drain(1'b1);
        check("b_nwr", 64'(wlog.size()), 64'd3);
        check("b_wr0", 64'(wlog[0]), 64'h0000);
        check("b_wr1", 64'(wlog[1]), 64'h012C);
        check("b_wr2", 64'(wlog[2]), 64'h0248);
`ifndef STI_PARITY_EN
        check("b_bits", sbits(), 64'h002C48);
`endif

        // address continues across frames
        send(16'h00F1, 1, 0, 0, 0, 0);
        wait_drain(1'b1);
        check("e_wr0", 64'(wlog[0]), 64'h038F);
        check("e_wr1", 64'(wlog[1]), 64'h0400);
        send(16'h00F1, 0, 0, 0, 0, 0);
        wait_drain(1'b1);
        check("e2_wr0", 64'(wlog[0]), 64'h058F);

        // loads during DAC and SER are ignored
        send(16'h0007, 0, 0, 1, 0, 0);
        load = 1'b1; pi_data = 16'hFFFF;
        tick();
        load = 1'b0;
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_drain(1'b1);
        check("p_nwr", 64'(wlog.size()), 64'd1);
        check("p_wr0", 64'(wlog[0]), 64'h0607);
`ifdef STI_PARITY_EN
        check("p_nbits", 64'(slog.size()), 64'd9);
        check("p_bits", sbits(), 64'h00F);
`else
        check("p_nbits", 64'(slog.size()), 64'd8);
        check("p_bits", sbits(), 64'h07);
`endif

        // reset during serial bit 5 of a 16-bit frame (bit 5 is cycle 9)
        send(16'hBEEF, 1, 0, 1, 0, 0);
        repeat (8) tick();
        do_reset(1'b0);
        check("rst_mid", 64'({ready, pixel_wr, pixel_addr, pixel_dataout,
                              so_valid, so_data, pixel_finish}), 64'h100000);
        // reset beats load in the same cycle
        pi_data = 16'h5555; pi_length = 2'd0;
        do_reset(1'b1);
        tick();
        check("rst_load", 64'({ready, pixel_wr, pixel_addr}), 64'h200);
        send(16'hA5C3, 0, 0, 1, 1, 0);
        wait_drain(1'b1);
        check("d_wr0", 64'(wlog[0]), 64'h00A5);

        // last word with tail fill
        do_reset(1'b0);
        send(16'hBEEF, 3, 0, 1, 0, 1);
        wait_drain(1'b0);
        check("f_nwr", 64'(wlog.size()), 64'd256);
        check("f_wr0", 64'(wlog[0]), 64'h0000);
        check("f_wr1", 64'(wlog[1]), 64'h0100);
        check("f_wr2", 64'(wlog[2]), 64'h02BE);
        check("f_wr3", 64'(wlog[3]), 64'h03EF);
        check("f_wr4", 64'(wlog[4]), 64'h0400);
        check("f_wrlast", 64'(wlog[255]), 64'hFF00);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        check("f_done", 64'({ready, pixel_wr, pixel_finish}), 64'h1);
        do_reset(1'b0);
        check("f_reset", 64'({ready, pixel_wr, pixel_addr, pixel_dataout,
                              so_valid, so_data, pixel_finish}), 64'h100000);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
